// File: rtl/antares_seq_divider_pkg.sv
// Shared defines for the ALU divider: widths, iteration count, state encoding
// and operand magnitude helpers.
package antares_seq_divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT  = 32;
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  // Magnitude of a possibly-signed operand; 0x80000000 maps to itself (unsigned 2^31).
  function automatic logic [DIV_WIDTH_DEFAULT-1:0] div_mag(
    input logic [DIV_WIDTH_DEFAULT-1:0] value,
    input logic                         is_signed
  );
    return (is_signed && value[DIV_WIDTH_DEFAULT-1]) ?
           (~value + DIV_WIDTH_DEFAULT'(1)) : value;
  endfunction

  function automatic logic [DIV_WIDTH_DEFAULT-1:0] div_negate(
    input logic [DIV_WIDTH_DEFAULT-1:0] value,
    input logic                         neg
  );
    return neg ? (~value + DIV_WIDTH_DEFAULT'(1)) : value;
  endfunction

endpackage

// File: rtl/antares_seq_divider.sv
// Multi-cycle radix-2 restoring divider for the execute-stage ALU; one
// quotient bit per cycle, remainder sign follows the dividend.
module antares_seq_divider
  import antares_seq_divider_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_divs,
  input  logic                 op_divu,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_stall
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  div_state_e           state;
  logic [DIV_WIDTH-1:0] quo_reg;
  logic [DIV_WIDTH-1:0] rem_reg;
  logic [DIV_WIDTH-1:0] dsr_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 neg_q;
  logic                 neg_r;

  logic                 start;
  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH:0]   trial;
  logic                 trial_neg;
  logic [DIV_WIDTH-1:0] next_rem;
  logic [DIV_WIDTH-1:0] next_quo;

  assign start = op_divs | op_divu;

  // One restoring step; the 33-bit trial keeps the borrow in its top bit.
  always_comb begin
    shifted   = {rem_reg, quo_reg[DIV_WIDTH-1]};
    trial     = shifted - {1'b0, dsr_reg};
    trial_neg = trial[DIV_WIDTH];
    next_rem  = trial_neg ? shifted[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    next_quo  = {quo_reg[DIV_WIDTH-2:0], ~trial_neg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Signed wins when both start strobes are high.
            quo_reg   <= div_mag(dividend, op_divs);
            dsr_reg   <= div_mag(divisor, op_divs);
            rem_reg   <= '0;
            cnt_reg   <= CNT_W'(DIV_CYCLES - 1);
            neg_q     <= op_divs & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
            neg_r     <= op_divs & dividend[DIV_WIDTH-1];
            div_stall <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          quo_reg <= next_quo;
          rem_reg <= next_rem;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == '0) begin
            div_stall <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          div_stall <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Sign correction from registered magnitudes and flags.
  assign quotient  = div_negate(quo_reg, neg_q);
  assign remainder = div_negate(rem_reg, neg_r);

endmodule
